// File: rtl/vga_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// vga_pkg : shared constants and palette reset helper for the VGA scanout
// Rev 1.0 : initial release
// ============================================================================
package vga_pkg;

   localparam int H_VISIBLE      = 640;
   localparam int V_VISIBLE      = 480;
   localparam int FB_W           = 320;
   localparam int FB_H           = 240;
   localparam int WORDS_PER_LINE = FB_W / 4;
   localparam int PIPE_LAT       = 3;
   localparam int RGB_W          = 12;
   localparam int PAL_N          = 16;

   typedef logic [RGB_W-1:0] rgb444_t;

   // Grey ramp: entry i holds {i,i,i}.
   function automatic rgb444_t pal_reset_value(input logic [3:0] idx);
      return {idx, idx, idx};
   endfunction

endpackage
`default_nettype wire

// File: rtl/fb_palette.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// fb_palette : 16x12 palette register file, one write port, async read port
// Rev 1.0 : initial release
// ============================================================================
module fb_palette
   import vga_pkg::*;
(
   input  logic             clk_25mhz,
   input  logic             resetn,
   input  logic             we,
   input  logic [3:0]       widx,
   input  logic [RGB_W-1:0] wdata,
   input  logic [3:0]       ridx,
   output logic [RGB_W-1:0] rdata
);

   logic [PAL_N*RGB_W-1:0] pal_flat;

   for (genvar i = 0; i < PAL_N; i++) begin : g_entry
      logic [RGB_W-1:0] ent_d;
      logic [RGB_W-1:0] ent_q;

      always_comb begin
         ent_d = ent_q;
         if (we && (widx == 4'(i))) begin
            ent_d = wdata;
         end
      end

      always_ff @(posedge clk_25mhz) begin
         if (!resetn) begin
            ent_q <= pal_reset_value(4'(i));
         end else begin
            ent_q <= ent_d;
         end
      end

      assign pal_flat[i*RGB_W +: RGB_W] = ent_q;
   end

   // Read sees the stored value, so a same-cycle write shows up one clock later.
   always_comb begin
      rdata = '0;
      for (int k = 0; k < PAL_N; k++) begin
         if (ridx == 4'(k)) begin
            rdata = pal_flat[k*RGB_W +: RGB_W];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/spram_fb_scanout.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// spram_fb_scanout : 320x240 4-bpp SPRAM framebuffer scanout, 2x doubled,
//                    palette-expanded to RGB444 with blanking-time host writes
// Rev 1.0 : initial release
// ============================================================================
module spram_fb_scanout #(
   parameter int FB_W           = vga_pkg::FB_W,
   parameter int FB_H           = vga_pkg::FB_H,
   parameter int WORDS_PER_LINE = vga_pkg::WORDS_PER_LINE,
   parameter int ADDR_W         = 15
) (
   input  logic                      clk_25mhz,
   input  logic                      resetn,
   input  logic [9:0]                hpos,
   input  logic [9:0]                vpos,
   input  logic                      hsync_in,
   input  logic                      vsync_in,
   input  logic                      display_valid,
   output logic [ADDR_W-1:0]         spram_addr,
   output logic [15:0]               spram_din,
   output logic                      spram_wren,
   input  logic [15:0]               spram_dout,
   input  logic                      wr_valid,
   output logic                      wr_ready,
   input  logic [ADDR_W-1:0]         wr_addr,
   input  logic [15:0]               wr_data,
   input  logic                      pal_we,
   input  logic [3:0]                pal_idx,
   input  logic [vga_pkg::RGB_W-1:0] pal_rgb,
   output logic [vga_pkg::RGB_W-1:0] rgb,
   output logic                      hsync_out,
   output logic                      vsync_out,
   output logic                      de_out
);

   import vga_pkg::*;

   logic [7:0]        row;
   logic [6:0]        col;
   logic [ADDR_W-1:0] rd_addr;

   logic [ADDR_W-1:0] spram_addr_d, spram_addr_q;
   logic [15:0]       spram_din_d,  spram_din_q;
   logic              spram_wren_d, spram_wren_q;

   logic [1:0]        s1_sel_d, s1_sel_q;
   logic              s1_de_d,  s1_de_q;
   logic              s1_hs_d,  s1_hs_q;
   logic              s1_vs_d,  s1_vs_q;

   logic [1:0]        s2_sel_d, s2_sel_q;
   logic              s2_de_d,  s2_de_q;
   logic              s2_hs_d,  s2_hs_q;
   logic              s2_vs_d,  s2_vs_q;

   logic [3:0]        nib;
   logic [RGB_W-1:0]  pal_rd;
   logic [RGB_W-1:0]  rgb_d, rgb_q;
   logic              de_out_d, de_out_q;
   logic              hsync_out_d, hsync_out_q;
   logic              vsync_out_d, vsync_out_q;

   // row*80 + col built from shifts: each source row doubles onto two screen lines.
   assign row     = vpos[8:1];
   assign col     = hpos[9:3];
   assign rd_addr = ADDR_W'({row, 6'b0}) + ADDR_W'({row, 4'b0}) + ADDR_W'(col);

   assign wr_ready = resetn & ~display_valid;

   always_comb begin
      spram_addr_d = spram_addr_q;
      spram_din_d  = spram_din_q;
      spram_wren_d = 1'b0;
      if (display_valid) begin
         spram_addr_d = rd_addr;
      end else if (wr_valid && wr_ready) begin
         spram_addr_d = wr_addr;
         spram_din_d  = wr_data;
         spram_wren_d = 1'b1;
      end

      s1_sel_d = hpos[2:1];
      s1_de_d  = display_valid;
      s1_hs_d  = hsync_in;
      s1_vs_d  = vsync_in;

      s2_sel_d = s1_sel_q;
      s2_de_d  = s1_de_q;
      s2_hs_d  = s1_hs_q;
      s2_vs_d  = s1_vs_q;
   end

   // Leftmost screen pixel lives in the low nibble.
   always_comb begin
      case (s2_sel_q)
         2'd0:    nib = spram_dout[3:0];
         2'd1:    nib = spram_dout[7:4];
         2'd2:    nib = spram_dout[11:8];
         default: nib = spram_dout[15:12];
      endcase
   end

   fb_palette u_palette (
      .clk_25mhz (clk_25mhz),
      .resetn    (resetn),
      .we        (pal_we),
      .widx      (pal_idx),
      .wdata     (pal_rgb),
      .ridx      (nib),
      .rdata     (pal_rd)
   );

   always_comb begin
      rgb_d       = s2_de_q ? pal_rd : '0;
      de_out_d    = s2_de_q;
      hsync_out_d = s2_hs_q;
      vsync_out_d = s2_vs_q;
   end

   always_ff @(posedge clk_25mhz) begin
      if (!resetn) begin
         spram_addr_q <= '0;
         spram_din_q  <= '0;
         spram_wren_q <= 1'b0;
         s1_sel_q     <= '0;
         s1_de_q      <= 1'b0;
         s1_hs_q      <= 1'b1;
         s1_vs_q      <= 1'b1;
         s2_sel_q     <= '0;
         s2_de_q      <= 1'b0;
         s2_hs_q      <= 1'b1;
         s2_vs_q      <= 1'b1;
         rgb_q        <= '0;
         de_out_q     <= 1'b0;
         hsync_out_q  <= 1'b1;
         vsync_out_q  <= 1'b1;
      end else begin
         spram_addr_q <= spram_addr_d;
         spram_din_q  <= spram_din_d;
         spram_wren_q <= spram_wren_d;
         s1_sel_q     <= s1_sel_d;
         s1_de_q      <= s1_de_d;
         s1_hs_q      <= s1_hs_d;
         s1_vs_q      <= s1_vs_d;
         s2_sel_q     <= s2_sel_d;
         s2_de_q      <= s2_de_d;
         s2_hs_q      <= s2_hs_d;
         s2_vs_q      <= s2_vs_d;
         rgb_q        <= rgb_d;
         de_out_q     <= de_out_d;
         hsync_out_q  <= hsync_out_d;
         vsync_out_q  <= vsync_out_d;
      end
   end

   assign spram_addr = spram_addr_q;
   assign spram_din  = spram_din_q;
   assign spram_wren = spram_wren_q;
   assign rgb        = rgb_q;
   assign de_out     = de_out_q;
   assign hsync_out  = hsync_out_q;
   assign vsync_out  = vsync_out_q;

   // Bits dropped by the 2x downscale and the geometry parameters fixed by the shift-add.
   logic unused_ok;
   assign unused_ok = ^{hpos[0], vpos[9], vpos[0],
                        1'(FB_W), 1'(FB_H), 1'(WORDS_PER_LINE)};

endmodule
`default_nettype wire
